// File: rtl/sig_abc_pkg.sv
// Shared definitions for the sig_abc request/response block.
// Contents:
//   state_e  - FSM state encoding (IDLE, BUSY, RESP)
//   LAT_MAX  - largest legal service latency
//   CNT_W    - latency counter width, sized to hold LAT_MAX
package sig_abc_pkg;

    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sig_abc_lat_ctr.sv
// Latency down-counter for sig_abc_responder.
// Ports:
//   clk      - clock, all updates on rising edge
//   rst_n    - synchronous active-low reset, clears the count
//   load     - load load_val (takes priority over dec)
//   load_val - value loaded on load
//   dec      - decrement by one; holds at zero
//   zero     - count is zero
module sig_abc_lat_ctr
    import sig_abc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sig_abc_responder.sv
// Request/response responder: accepts a request strobe with payload while idle,
// spends LAT cycles busy, then presents payload + LAT until downstream accepts.
// Parameters:
//   DATA_W - payload width
//   LAT    - service latency in cycles, 1..LAT_MAX
// Ports:
//   clk       - clock, all updates on rising edge
//   rst_n     - synchronous active-low reset
//   signal_a  - request strobe (ignored unless idle)
//   req_data  - request payload, sampled with signal_a
//   signal_b  - busy: request in service (BUSY or RESP)
//   signal_c  - ready: idle
//   rsp_valid - response valid
//   rsp_data  - response payload, holds its last value outside RESP
//   rsp_ready - downstream accepts response
// Build option: define SIG_ABC_RESPONDER_SVA_EN to compile in protocol assertions.
module sig_abc_responder
    import sig_abc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LAT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              signal_a,
    input  logic [DATA_W-1:0] req_data,
    output logic              signal_b,
    output logic              signal_c,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready
);

    if ((LAT < 1) || (LAT > LAT_MAX)) begin : g_lat_check
        $error("sig_abc_responder: LAT must be in 1..LAT_MAX");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic              ctr_load, ctr_dec, ctr_zero;

    sig_abc_lat_ctr u_lat_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (CNT_W'(LAT - 1)),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rsp_d    = rsp_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (signal_a) begin
                    ctr_load = 1'b1;
                    data_d   = req_data;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (ctr_zero) begin
                    // Sum wraps modulo 2^DATA_W by truncation.
                    rsp_d   = data_q + DATA_W'(LAT);
                    state_d = RESP;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode, so they line up
    // with state_q and never glitch from inputs.
    always_comb begin
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
        vld_d  = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

    assign signal_b  = busy_q;
    assign signal_c  = rdy_q;
    assign rsp_valid = vld_q;
    assign rsp_data  = rsp_q;

`ifdef SIG_ABC_RESPONDER_SVA_EN
    a_accept_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (signal_a && !signal_b) |=> (!signal_c && signal_b));

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data)));

    a_busy_rdy_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(signal_b && signal_c));
`endif

endmodule

// File: doc/sig_abc_responder.md
SIG_ABC_RESPONDER -- requirements
Module: sig_abc_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning request/response payload width.
REQ-002 SHALL have parameter LAT, default 3, legal 1..15, meaning service cycles spent in BUSY.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port signal_a, input, 1, request strobe.
REQ-006 SHALL have port req_data, input, DATA_W, payload sampled with signal_a.
REQ-007 SHALL have port signal_b, output, 1, busy; high while a request is in service.
REQ-008 SHALL have port signal_c, output, 1, ready; high only when idle.
REQ-009 SHALL have port rsp_valid, output, 1, response valid.
REQ-010 SHALL have port rsp_data, output, DATA_W, response payload.
REQ-011 SHALL have port rsp_ready, input, 1, downstream accepts response.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP; outputs registered, decoded from state only.
REQ-013 SHALL drive IDLE: signal_b=0, signal_c=1, rsp_valid=0.
REQ-014 SHALL drive BUSY: signal_b=1, signal_c=0, rsp_valid=0.
REQ-015 SHALL drive RESP: signal_b=1, signal_c=0, rsp_valid=1.
REQ-016 SHALL, in IDLE with signal_a=1 at an edge, capture req_data, load counter with LAT-1, enter BUSY; hence signal_b=1 and signal_c=0 in the next cycle.
REQ-017 SHALL, in BUSY, decrement counter each edge; at an edge where counter==0, enter RESP.
REQ-018 SHALL make the first rsp_valid cycle follow edge T+LAT, where T is the accepting edge.
REQ-019 SHALL compute rsp_data = captured data + LAT, modulo 2^DATA_W (wrap, no saturation).
REQ-020 SHALL hold rsp_valid and rsp_data stable in RESP until an edge with rsp_ready=1, then enter IDLE.
REQ-021 SHALL ignore signal_a in BUSY and RESP, including the RESP edge where rsp_ready=1.
REQ-022 SHALL accept a new request no earlier than the first edge with IDLE state.
REQ-023 SHALL keep rsp_data at its last value outside RESP.

Reset
REQ-024 SHALL, at any edge with rst_n=0, enter IDLE and clear counter, captured data and rsp_data to 0; signal_b=0, signal_c=1, rsp_valid=0 the next cycle.
REQ-025 SHALL abandon any in-flight request on mid-operation reset, with no response emitted.
REQ-026 SHALL give rst_n priority over signal_a on the same edge.

Configuration
REQ-027 SHALL compile in, when SIG_ABC_RESPONDER_SVA_EN is defined, concurrent assertions at posedge clk, disabled while !rst_n:
- (signal_a && !signal_b) |=> (!signal_c && signal_b)
- rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data)
- !(signal_b && signal_c)
REQ-028 SHALL, without SIG_ABC_RESPONDER_SVA_EN, contain no assertions, with identical RTL behaviour.

Structure
REQ-029 SHALL place state enum typedef (IDLE/BUSY/RESP) and constant LAT_MAX=15 in package sig_abc_pkg.
REQ-030 SHALL implement the latency down-counter (load, decrement, zero flag) as sub-module sig_abc_lat_ctr.
REQ-031 SHALL error at elaboration if LAT<1 or LAT>LAT_MAX.

Verification (DATA_W=8, LAT=3)
REQ-032 SHALL test reset: rst_n=0 for 2 edges -> signal_b=0, signal_c=1, rsp_valid=0, rsp_data=0x00.
REQ-033 SHALL test basic request: signal_a=1, req_data=0x12 at edge T -> signal_b=1, signal_c=0 after T; rsp_valid=1, rsp_data=0x15 after T+3; rsp_ready=1 at T+4 -> IDLE after T+4.
REQ-034 SHALL test wrap: req_data=0xFE -> rsp_data=0x01.
REQ-035 SHALL test ignored requests and backpressure: signal_a=1 every cycle in BUSY/RESP with rsp_ready=0 for 5 RESP cycles -> rsp_valid and rsp_data held, signal_b=1, no second capture.
REQ-036 SHALL test reset mid-operation: rst_n=0 at second BUSY edge -> IDLE next cycle, rsp_valid never asserted.
REQ-037 SHALL test with SIG_ABC_RESPONDER_SVA_EN defined: all above run with zero assertion failures.
